// File: rtl/rambam_sbox_iter_if.sv
// rambam_sbox_iter_if: job/result handshake bundle for the iterative RAMBAM S-box
interface rambam_sbox_iter_if #(
  parameter int LANES = 4,
  parameter int D = 4
);
  logic in_valid;
  logic in_ready;
  logic inv;
  logic [LANES*(8+D)-1:0] in_data;
  logic [LANES*D-1:0] r;
  logic out_valid;
  logic out_ready;
  logic [LANES*(8+D)-1:0] out_data;
  logic busy;
  modport master (
    output in_valid, inv, in_data, r, out_ready,
    input in_ready, out_valid, out_data, busy
  );
  modport slave (
    input in_valid, inv, in_data, r, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/rambam_sbox_iter.sv
// rambam_sbox_iter: multi-lane iterative AES S-box / inverse S-box over the RAMBAM
// redundant ring GF(2)[X]/(P*Q), computing x^254 with one multiplier and one matrix unit per lane.
module rambam_sbox_iter #(
  parameter int d = 4,
  parameter logic [8:0] P = 9'h11B,
  parameter logic [d:0] Q = 5'h13,
  parameter int LANES = 4,
  parameter logic [63:0] W_INV = 64'h5229944A259249A4,
  parameter logic [7:0] w_INV = 8'h05
) (
  input logic clk,
  input logic rst,
  rambam_sbox_iter_if.slave bus
);
  localparam int N = 8 + d;
  localparam logic [63:0] W = 64'hF87C3E1F8FC7E3F1;
  localparam logic [7:0] w = 8'h63;

  function automatic logic [N:0] pq_calc();
    logic [N:0] acc;
    logic [N:0] pe;
    acc = '0;
    pe = '0;
    pe[8:0] = P;
    for (int i = 0; i <= d; i++) if (Q[i]) acc ^= pe << i;
    return acc;
  endfunction

  localparam logic [N:0] PQ = pq_calc();

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-2:0] p;
    logic [2*N-2:0] ae;
    logic [2*N-2:0] m;
    p = '0;
    ae = '0;
    ae[N-1:0] = a;
    m = '0;
    m[N:0] = PQ;
    for (int i = 0; i < N; i++) if (b[i]) p ^= ae << i;
    for (int i = 2*N-2; i >= N; i--) if (p[i]) p ^= m << (i - N);
    return p[N-1:0];
  endfunction

  // Squaring is GF(2)-linear in this ring, so x^(2^k) collapses to a constant matrix.
  function automatic logic [N*N-1:0] matgen(input int k);
    logic [N*N-1:0] m;
    logic [N-1:0] e;
    m = '0;
    for (int j = 0; j < N; j++) begin
      e = '0;
      e[j] = 1'b1;
      for (int s = 0; s < k; s++) e = mulmod(e, e);
      m[j*N +: N] = e;
    end
    return m;
  endfunction

  localparam logic [N*N-1:0] M1 = matgen(1);
  localparam logic [N*N-1:0] M2 = matgen(2);
  localparam logic [N*N-1:0] M4 = matgen(4);

  function automatic logic [N-1:0] matvec(input logic [N*N-1:0] m, input logic [N-1:0] x);
    logic [N-1:0] y;
    y = '0;
    for (int j = 0; j < N; j++) if (x[j]) y ^= m[j*N +: N];
    return y;
  endfunction

  function automatic logic [7:0] modp(input logic [N-1:0] x);
    logic [N-1:0] pe;
    pe = '0;
    pe[8:0] = P;
    for (int i = N-1; i >= 8; i--) if (x[i]) x ^= pe << (i - 8);
    return x[7:0];
  endfunction

  function automatic logic [N-1:0] refresh(input logic [N-1:0] x, input logic [d-1:0] rr);
    logic [N-1:0] pe;
    pe = '0;
    pe[8:0] = P;
    for (int i = 0; i < d; i++) if (rr[i]) x ^= pe << i;
    return x;
  endfunction

  function automatic logic [7:0] affine(input logic [63:0] m, input logic [7:0] c, input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^(m[8*i +: 8] & x) ^ c[i];
    return y;
  endfunction

  typedef enum logic [1:0] {IDLE, PRE, STEP, DONE} state_t;

  state_t r_state;
  logic [2:0] r_stage;
  logic r_inv;
  logic r_in_ready;
  logic r_out_valid;
  logic r_busy;
  logic [LANES-1:0][N-1:0] r_t1, r_t2, r_t3, r_t12, r_t14, r_t15, r_t240, r_out;
  logic [LANES-1:0][N-1:0] w_new, w_pre, w_fin;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [d-1:0] w_r;
    logic [N-1:0] w_mat;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_raw;
    assign w_r = bus.r[g*d +: d];
    assign w_mat = matvec(r_stage == 3'd0 ? M1 : r_stage == 3'd2 ? M2 : M4,
                          r_stage == 3'd0 ? r_t1[g] : r_stage == 3'd2 ? r_t3[g] : r_t15[g]);
    assign w_a = r_stage == 3'd1 ? r_t1[g] : r_stage == 3'd3 ? r_t2[g] : r_stage == 3'd4 ? r_t3[g] : r_t14[g];
    assign w_b = r_stage == 3'd1 ? r_t2[g] : r_stage == 3'd6 ? r_t240[g] : r_t12[g];
    assign w_raw = (r_stage == 3'd0 || r_stage == 3'd2 || r_stage == 3'd5) ? w_mat : mulmod(w_a, w_b);
    assign w_new[g] = refresh(w_raw, w_r);
    assign w_pre[g] = refresh({{d{1'b0}}, affine(W_INV, w_INV, modp(r_t1[g]))}, w_r);
    assign w_fin[g] = r_inv ? w_new[g] : {{d{1'b0}}, affine(W, w, modp(w_new[g]))};
  end

  // Result handshake zeroizes exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || (r_state == DONE && bus.out_ready)) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_inv <= 1'b0;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy <= 1'b0;
      r_t1 <= '0;
      r_t2 <= '0;
      r_t3 <= '0;
      r_t12 <= '0;
      r_t14 <= '0;
      r_t15 <= '0;
      r_t240 <= '0;
      r_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_t1 <= bus.in_data;
          r_inv <= bus.inv;
          r_stage <= '0;
          r_state <= bus.inv ? PRE : STEP;
          r_in_ready <= 1'b0;
          r_busy <= 1'b1;
        end
        PRE: begin
          r_t1 <= w_pre;
          r_state <= STEP;
        end
        STEP: begin
          r_t2 <= r_stage == 3'd0 ? w_new : r_t2;
          r_t3 <= r_stage == 3'd1 ? w_new : r_t3;
          r_t12 <= r_stage == 3'd2 ? w_new : r_t12;
          r_t14 <= r_stage == 3'd3 ? w_new : r_t14;
          r_t15 <= r_stage == 3'd4 ? w_new : r_t15;
          r_t240 <= r_stage == 3'd5 ? w_new : r_t240;
          r_out <= r_stage == 3'd6 ? w_fin : r_out;
          r_stage <= r_stage + 3'd1;
          if (r_stage == 3'd6) begin
            r_state <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy = r_busy;
  assign bus.out_data = r_out;
endmodule

// File: tb/tb_rambam_sbox_iter.sv
// tb_rambam_sbox_iter: directed and exhaustive checks of the iterative RAMBAM S-box
module tb_rambam_sbox_iter;
  localparam int D = 4;
  localparam int LANES = 4;
  localparam int N = 8 + D;

  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];

  always #5 clk = ~clk;

  rambam_sbox_iter_if #(.LANES(LANES), .D(D)) bus ();
  rambam_sbox_iter #(.d(D), .LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      hi = a[7];
      a = a << 1;
      if (hi) a ^= 8'h1B;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] iv;
    iv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
    return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
  endfunction

  function automatic logic [11:0] encode(input logic [7:0] b, input bit en);
    logic [11:0] v;
    logic [3:0] k;
    v = {4'h0, b};
    k = en ? 4'($urandom) : 4'h0;
    for (int i = 0; i < 4; i++) if (k[i]) v ^= 12'h11B << i;
    return v;
  endfunction

  function automatic logic [7:0] decode(input logic [11:0] v);
    for (int i = 11; i >= 8; i--) if (v[i]) v ^= 12'h11B << (i - 8);
    return v[7:0];
  endfunction

  task automatic run_job(input logic [31:0] bytes, input logic iv, input bit en,
                         output logic [31:0] dec, output int lat);
    logic [LANES*N-1:0] enc;
    for (int l = 0; l < LANES; l++) enc[l*N +: N] = encode(bytes[l*8 +: 8], en);
    @(negedge clk);
    bus.in_data = enc;
    bus.inv = iv;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.r = en ? 16'($urandom) : 16'h0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      bus.r = en ? 16'($urandom) : 16'h0;
      @(posedge clk);
      #1;
      lat++;
    end
    for (int l = 0; l < LANES; l++) dec[l*8 +: 8] = decode(bus.out_data[l*N +: N]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h, required 0", bus.out_data); end
    rst = 1'b0;
  endtask

  task automatic test_fwd_zero();
    logic [31:0] dec;
    int lat;
    run_job(32'h00000000, 1'b0, 1'b0, dec, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL fwd_zero_latency: got %0d, required 8", lat); end
    checks++; if (dec !== 32'h63636363) begin errors++; $display("FAIL fwd_zero_data: got %h, required 63636363", dec); end
  endtask

  task automatic test_fwd_vectors();
    logic [31:0] dec;
    int lat;
    run_job(32'h10FF0153, 1'b0, 1'b1, dec, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL fwd_vec_latency: got %0d, required 8", lat); end
    checks++; if (dec !== 32'hCA167CED) begin errors++; $display("FAIL fwd_vec_data: got %h, required CA167CED", dec); end
  endtask

  task automatic test_inv_vectors();
    logic [31:0] dec;
    int lat;
    run_job(32'h167CED63, 1'b1, 1'b1, dec, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL inv_vec_latency: got %0d, required 9", lat); end
    checks++; if (dec !== 32'hFF015300) begin errors++; $display("FAIL inv_vec_data: got %h, required FF015300", dec); end
  endtask

  task automatic test_backpressure();
    logic [LANES*N-1:0] held;
    logic [31:0] dec;
    int n;
    int seen;
    @(negedge clk);
    for (int l = 0; l < LANES; l++) bus.in_data[l*N +: N] = encode(8'h53, 1'b1);
    bus.inv = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    bus.r = 16'($urandom);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      bus.r = 16'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_done: got out_valid=%b, required 1", bus.out_valid); end
    held = bus.out_data;
    for (int l = 0; l < LANES; l++) dec[l*8 +: 8] = decode(held[l*N +: N]);
    checks++; if (dec !== 32'hEDEDEDED) begin errors++; $display("FAIL bp_data: got %h, required EDEDEDED", dec); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.inv = 1'($urandom);
      bus.in_data = {16'($urandom), 32'($urandom)};
      bus.r = 16'($urandom);
      @(posedge clk);
      #1;
      checks++; if (bus.out_data !== held) begin errors++; $display("FAIL bp_stable_%0d: got %h, required %h", c, bus.out_data, held); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b, required 0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d: got %b, required 1", c, bus.out_valid); end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_in_ready: got %b, required 1", bus.in_ready); end
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL bp_ignored_pulses: got %0d active cycles, required 0", seen); end
  endtask

  task automatic test_reset_midjob();
    logic [31:0] dec;
    int lat;
    int seen;
    @(negedge clk);
    for (int l = 0; l < LANES; l++) bus.in_data[l*N +: N] = encode(8'h01, 1'b1);
    bus.inv = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      bus.r = 16'($urandom);
      @(posedge clk);
      #1;
    end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", bus.busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b, required 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %b, required 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL mid_rst_out_data: got %h, required 0", bus.out_data); end
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_discarded: got %0d valid cycles, required 0", seen); end
    run_job(32'h53535353, 1'b0, 1'b1, dec, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL mid_next_latency: got %0d, required 8", lat); end
    checks++; if (dec !== 32'hEDEDEDED) begin errors++; $display("FAIL mid_next_data: got %h, required EDEDEDED", dec); end
  endtask

  task automatic test_exhaustive();
    logic [31:0] bytes;
    logic [31:0] dec;
    logic [7:0] exp;
    int lat;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 64; k++) begin
        for (int l = 0; l < LANES; l++) bytes[l*8 +: 8] = 8'(4*k + l);
        run_job(bytes, 1'(m), 1'b1, dec, lat);
        checks++; if (lat !== 8 + m) begin errors++; $display("FAIL exh_latency m=%0d k=%0d: got %0d, required %0d", m, k, lat, 8 + m); end
        for (int l = 0; l < LANES; l++) begin
          exp = m == 1 ? isbox_t[bytes[l*8 +: 8]] : sbox_t[bytes[l*8 +: 8]];
          checks++;
          if (dec[l*8 +: 8] !== exp) begin
            errors++;
            $display("FAIL exh m=%0d in=%h: got %h, required %h", m, bytes[l*8 +: 8], dec[l*8 +: 8], exp);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.inv = 1'b0;
    bus.in_data = '0;
    bus.r = '0;
    bus.out_ready = 1'b0;
    for (int x = 0; x < 256; x++) begin
      sbox_t[x] = sbox_model(8'(x));
      isbox_t[sbox_t[x]] = 8'(x);
    end
    test_reset();
    test_fwd_zero();
    test_fwd_vectors();
    test_inv_vectors();
    test_backpressure();
    test_reset_midjob();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rambam_sbox_iter.md
RAMBAM_SBOX_ITER -- requirements
Module: rambam_sbox_iter

Interface
REQ-001 The block SHALL have parameter d, default `d: number of redundancy bits per byte; each element is 8+d bits wide.
REQ-002 The block SHALL have parameter P, default `P (9 bits): AES field polynomial.
REQ-003 The block SHALL have parameter Q, default `Q (d+1 bits): redundancy polynomial; PQ, W, w, pow1, pow2 and pow4 are derived from the same include macros.
REQ-004 The block SHALL have parameter LANES, default 4: number of independent bytes processed in parallel under one controller.
REQ-005 The block SHALL have parameter W_INV/w_INV, default `W_INV/`w_INV: inverse affine matrix and constant for the decrypt mode.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data/inv are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: block can accept a job.
REQ-010 The block SHALL have port in_data, input, LANES x (8+d) bits: redundant-representation input bytes.
REQ-011 The block SHALL have port inv, input, 1 bit: 0 = forward S-box, 1 = inverse S-box; sampled with in_data.
REQ-012 The block SHALL have port r, input, LANES x d bits: fresh randomness consumed every compute cycle.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-015 The block SHALL have port out_data, output, LANES x (8+d) bits: redundant-representation results.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, PRE, S0..S6 and DONE, with a 3-bit stage counter indexing S0..S6.
REQ-018 In IDLE, in_ready SHALL be 1; on in_valid&in_ready the block SHALL latch in_data and inv, then go to PRE if inv=1, else S0.
REQ-019 In PRE (inverse only), each lane SHALL apply the inverse affine transform (W_INV, w_INV) to the latched byte, refresh it with r, and go to S0.
REQ-020 S0..S6 SHALL compute, one step per cycle with one shared multiplier and one shared matrix unit per lane, the following chain:
- t2 = pow1(t1)
- t3 = t1*t2
- t12 = pow2(t3)
- t14 = t2*t12
- t15 = t3*t12
- t240 = pow4(t15)
- t254 = t14*t240
REQ-021 Every step result SHALL be refreshed as result + r_lane*P (mod PQ) before being registered; products SHALL be reduced mod PQ and all values SHALL stay 8+d bits.
REQ-022 After S6 the block SHALL enter DONE.
REQ-023 In DONE, out_data SHALL be the forward affine transform (W, w) of t254 when inv=0, and t254 unchanged when inv=1, driven from registers.
REQ-024 out_valid SHALL be 1 only in DONE.
REQ-025 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 On out_valid&out_ready the block SHALL return to IDLE and zeroize all intermediate registers.
REQ-027 in_ready SHALL be 0 outside IDLE, so in_valid is ignored while busy; no overlap between jobs.
REQ-028 Latency from the accepting handshake edge to out_valid SHALL be 8 cycles forward and 9 cycles inverse, independent of LANES and d.
REQ-029 r SHALL be sampled only in PRE and S0..S6; values on r in other states SHALL have no effect.
REQ-030 Decoded results (value mod P) SHALL be independent of r.

Reset
REQ-031 When rst=1 at a clock edge, the FSM SHALL go to IDLE, all data and intermediate registers SHALL clear to 0, and outputs SHALL read in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-032 rst SHALL take priority over every handshake; a job in flight is discarded and not output.

Verification
REQ-033 Forward, r=0, lane0 in=0x00 (redundancy 0), inv=0 -> out_valid exactly 8 cycles after accept; decoded lane0 = 0x63.
REQ-034 Forward, random r each cycle, lanes = {0x53,0x01,0xFF,0x10}, each with random multiple of P added -> decoded {0xED,0x7C,0x16,0xCA}.
REQ-035 Inverse, random r, lanes = {0x63,0xED,0x7C,0x16} -> out_valid 9 cycles after accept; decoded {0x00,0x53,0x01,0xFF}.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> out_data constant; in_ready=0; in_valid pulses ignored; one transfer when out_ready rises; in_ready=1 the next cycle.
REQ-037 rst=1 at S3 -> next cycle in_ready=1, out_valid=0, out_data=0; the following job (0x53 forward) yields 0xED with normal latency.
REQ-038 Exhaustive: all 256 bytes in both modes with random r and redundancy -> decoded results match the AES S-box and inverse S-box tables.
